// File: rtl/div_pkg.sv
// Shared helpers for the pipelined restoring divider: stage-mask decoding and latency.
package div_pkg;

    localparam int unsigned MAX_XLEN = 64;
    localparam int unsigned IDX_W    = 6;

    typedef logic [MAX_XLEN-1:0] mask_t;

    function automatic int unsigned popcount(input mask_t m);
        int unsigned n = 0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (m[i[IDX_W-1:0]]) n++;
        end
        return n;
    endfunction

    // True when iteration i is followed by a pipeline register.
    function automatic logic stage_reg(input mask_t m, input int unsigned i);
        return m[i[IDX_W-1:0]];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract b.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   r_in,
    input  logic            a_bit,
    input  logic [XLEN-1:0] b,
    output logic [XLEN:0]   r_out,
    output logic            q_bit
);

    logic [XLEN+1:0] r_sh;
    logic [XLEN+1:0] diff;

    assign r_sh  = {r_in, a_bit};
    // A clear sign bit on the trial difference means the shifted remainder was >= b.
    assign diff  = r_sh - {2'b00, b};
    assign q_bit = ~diff[XLEN+1];
    assign r_out = q_bit ? diff[XLEN:0] : r_sh[XLEN:0];

endmodule

// File: rtl/div_func.sv
// Unsigned pipelined restoring divider; STAGE_LIST picks which iterations end in a register.
module div_func
    import div_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] STAGE_LIST = 32'h0101_0101
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            vld,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            ack
);

    localparam mask_t       MASK = mask_t'(STAGE_LIST);
    localparam int unsigned LAT  = popcount(MASK);

    // Index i is the state entering iteration i; index XLEN is the finished result.
    logic [XLEN:0]   r_p    [0:XLEN];
    logic [XLEN-1:0] a_p    [0:XLEN];
    logic [XLEN-1:0] b_p    [0:XLEN];
    logic [XLEN-1:0] q_p    [0:XLEN];
    logic            vld_p  [0:XLEN];
    logic            live_p [0:XLEN];

    assign r_p[0]    = '0;
    assign a_p[0]    = a;
    assign b_p[0]    = b;
    assign q_p[0]    = '0;
    assign vld_p[0]  = vld;
    assign live_p[0] = 1'b1;

    genvar i;
    for (i = 0; i < XLEN; i++) begin : g_stage
        logic [XLEN:0]   r_n;
        logic            q_bit;
        logic [XLEN-1:0] q_n;

        div_step #(.XLEN(XLEN)) u_step (
            .r_in  (r_p[i]),
            .a_bit (a_p[i][XLEN-1-i]),
            .b     (b_p[i]),
            .r_out (r_n),
            .q_bit (q_bit)
        );

        always_comb begin
            q_n            = q_p[i];
            q_n[XLEN-1-i]  = q_bit;
        end

        if (stage_reg(MASK, i)) begin : g_reg
            logic [XLEN:0]   r_q;
            logic [XLEN-1:0] a_q, b_q, q_q;
            logic            vld_q, live_q;

            // Stage boundary after iteration i: data loads only with a valid op.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vld_q  <= 1'b0;
                    live_q <= 1'b0;
                    r_q    <= '0;
                    a_q    <= '0;
                    b_q    <= '0;
                    q_q    <= '0;
                end else begin
                    vld_q <= vld_p[i];
                    if (vld_p[i]) begin
                        live_q <= live_p[i];
                        r_q    <= r_n;
                        a_q    <= a_p[i];
                        b_q    <= b_p[i];
                        q_q    <= q_n;
                    end
                end
            end

            assign r_p[i+1]    = r_q;
            assign a_p[i+1]    = a_q;
            assign b_p[i+1]    = b_q;
            assign q_p[i+1]    = q_q;
            assign vld_p[i+1]  = vld_q;
            assign live_p[i+1] = live_q;
        end else begin : g_comb
            assign r_p[i+1]    = r_n;
            assign a_p[i+1]    = a_p[i];
            assign b_p[i+1]    = b_p[i];
            assign q_p[i+1]    = q_n;
            assign vld_p[i+1]  = vld_p[i];
            assign live_p[i+1] = live_p[i];
        end
    end

    // Until a first result lands, the cleared registers would otherwise decode as a
    // divide-by-zero; the live flag keeps quo/rem at zero instead.
    logic show;
    assign show = (LAT == 0) || live_p[XLEN];

    assign ack = vld_p[XLEN];
    assign quo = show ? q_p[XLEN] : '0;
    assign rem = show ? r_p[XLEN][XLEN-1:0] : '0;

endmodule

// File: tb/tb_div_func.sv
// Bench for div_func: three stage masks driven in lockstep against a plain-arithmetic model.
module tb_div_func;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;

    logic [31:0] quo4, rem4, quo0, rem0, quo32, rem32;
    logic        ack4, ack0, ack32;

    div_func #(.XLEN(32), .STAGE_LIST(32'h0101_0101)) u_l4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .vld(vld), .quo(quo4), .rem(rem4), .ack(ack4));
    div_func #(.XLEN(32), .STAGE_LIST(32'h0000_0000)) u_l0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .vld(vld), .quo(quo0), .rem(rem0), .ack(ack0));
    div_func #(.XLEN(32), .STAGE_LIST(32'hFFFF_FFFF)) u_l32 (
        .clk(clk), .rst(rst), .a(a), .b(b), .vld(vld), .quo(quo32), .rem(rem32), .ack(ack32));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int rel   = 0;

    logic        hv [0:4095];
    logic [31:0] ha [0:4095];
    logic [31:0] hb [0:4095];
    logic [31:0] lq [0:2];
    logic [31:0] lr [0:2];

    logic [31:0] sa [0:5] = '{32'd100, 32'd99, 32'd1, 32'd0, 32'd50, 32'd8};
    logic [31:0] sb [0:5] = '{32'd3,   32'd10, 32'd1, 32'd9, 32'd50, 32'd3};
    logic [31:0] sq [0:5] = '{32'd33,  32'd9,  32'd1, 32'd0, 32'd1,  32'd2};
    logic [31:0] sr [0:5] = '{32'd1,   32'd9,  32'd0, 32'd0, 32'd0,  32'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] q, output logic [31:0] r);
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = x;
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    task automatic check_dut(input int d, input int lat, input logic ack_o,
                             input logic [31:0] q_o, input logic [31:0] r_o);
        logic        e_ack;
        logic [31:0] eq, er;
        int          k;
        if (lat == 0) begin
            e_ack = vld;
            ref_div(a, b, eq, er);
        end else if (!rst) begin
            e_ack = 1'b0;
            lq[d] = '0;
            lr[d] = '0;
            eq    = '0;
            er    = '0;
        end else begin
            k     = cyc - lat;
            e_ack = 1'b0;
            if (k >= rel && hv[k]) begin
                e_ack = 1'b1;
                ref_div(ha[k], hb[k], lq[d], lr[d]);
            end
            eq = lq[d];
            er = lr[d];
        end
        chk($sformatf("ack_L%0d_c%0d", lat, cyc), {31'b0, ack_o}, {31'b0, e_ack});
        chk($sformatf("quo_L%0d_c%0d", lat, cyc), q_o, eq);
        chk($sformatf("rem_L%0d_c%0d", lat, cyc), r_o, er);
    endtask

    task automatic step(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                        input logic r = 1'b1);
        @(posedge clk);
        #1;
        if (cyc > 4095) begin
            $display("FAIL cycle_budget observed=%0d required<=4095", cyc);
            $fatal(1, "cycle budget exhausted");
        end
        if (r && !rst) rel = cyc;
        rst     = r;
        vld     = v;
        a       = aa;
        b       = bb;
        hv[cyc] = v;
        ha[cyc] = aa;
        hb[cyc] = bb;
        @(negedge clk);
        check_dut(0, 4, ack4, quo4, rem4);
        check_dut(1, 0, ack0, quo0, rem0);
        check_dut(2, 32, ack32, quo32, rem32);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 32'd0, 32'd0);
    endtask

    task automatic issue_wait(input string tag, input logic [31:0] aa, input logic [31:0] bb,
                              input logic [31:0] eq, input logic [31:0] er);
        step(1'b1, aa, bb);
        idle(3);
        chk({tag, "_early"}, {31'b0, ack4}, 32'd0);
        idle(1);
        chk({tag, "_ack"}, {31'b0, ack4}, 32'd1);
        chk({tag, "_quo"}, quo4, eq);
        chk({tag, "_rem"}, rem4, er);
    endtask

    initial begin
        lq = '{default: '0};
        lr = '{default: '0};

        step(1'b0, 32'd0, 32'd0, 1'b0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("reset_ack", {31'b0, ack4}, 32'd0);
        chk("reset_quo", quo4, 32'd0);
        chk("reset_rem", rem4, 32'd0);
        idle(2);
        chk("post_reset_quo", quo4, 32'd0);

        // Basic latency and hold, plus the combinational configuration.
        step(1'b1, 32'd625, 32'd5);
        chk("l0_ack", {31'b0, ack0}, 32'd1);
        chk("l0_quo", quo0, 32'd125);
        for (int j = 0; j < 3; j++) begin
            idle(1);
            chk("t1_early_ack", {31'b0, ack4}, 32'd0);
        end
        idle(1);
        chk("t1_ack", {31'b0, ack4}, 32'd1);
        chk("t1_quo", quo4, 32'd125);
        chk("t1_rem", rem4, 32'd0);
        idle(1);
        chk("t1_ack_drop", {31'b0, ack4}, 32'd0);
        chk("t1_hold_quo", quo4, 32'd125);
        chk("t1_hold_rem", rem4, 32'd0);
        idle(30);

        // Fully registered configuration: latency 32.
        step(1'b1, 32'd625, 32'd5);
        idle(31);
        chk("l32_early_ack", {31'b0, ack32}, 32'd0);
        idle(1);
        chk("l32_ack", {31'b0, ack32}, 32'd1);
        chk("l32_quo", quo32, 32'd125);

        issue_wait("small", 32'd5, 32'd7, 32'd0, 32'd5);
        issue_wait("by_one", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
        issue_wait("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0);
        issue_wait("div0", 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);

        // Back-to-back stream.
        for (int j = 0; j < 10; j++) begin
            if (j < 6) step(1'b1, sa[j], sb[j]);
            else       step(1'b0, 32'd0, 32'd0);
            if (j >= 4) begin
                chk($sformatf("stream_ack%0d", j - 4), {31'b0, ack4}, 32'd1);
                chk($sformatf("stream_quo%0d", j - 4), quo4, sq[j - 4]);
                chk($sformatf("stream_rem%0d", j - 4), rem4, sr[j - 4]);
            end else begin
                chk("stream_pre_ack", {31'b0, ack4}, 32'd0);
            end
        end
        idle(1);
        chk("stream_end_ack", {31'b0, ack4}, 32'd0);
        idle(30);

        // Reset while an op is in flight.
        step(1'b1, 32'd625, 32'd5);
        idle(1);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        chk("midrst_ack", {31'b0, ack4}, 32'd0);
        chk("midrst_quo", quo4, 32'd0);
        chk("midrst_rem", rem4, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            idle(1);
            chk("midrst_no_ack", {31'b0, ack4}, 32'd0);
            chk("midrst_quo_zero", quo4, 32'd0);
        end
        issue_wait("after_rst", 32'd81, 32'd9, 32'd9, 32'd0);

        // Random traffic for all three configurations.
        for (int n = 0; n < 1000; ) begin
            logic        v;
            logic [31:0] x, y;
            v = ($urandom_range(0, 3) != 0);
            x = $urandom;
            case ($urandom_range(0, 3))
                0:       y = $urandom;
                1:       y = $urandom_range(0, 15);
                2:       y = x >> $urandom_range(0, 31);
                default: y = $urandom & 32'h0000_FFFF;
            endcase
            step(v, x, y);
            if (v) n++;
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
